// File: rtl/fsm_mon_pkg.sv
// rtl/fsm_mon_pkg.sv - shared constants and transition rules for the ring FSM monitor
package fsm_mon_pkg;

    localparam int ST_W          = 3;
    localparam int NUM_STATES    = 7;
    localparam int CNT_W_DEF     = 16;
    localparam int LOG_DEPTH_DEF = 8;

    // Log entry layout: {from, to, dwell}, from in the MSBs
    localparam int DWELL_LSB = 0;

    typedef logic [ST_W-1:0] st_t;

    function automatic int to_lsb(input int cnt_w);
        return cnt_w;
    endfunction

    function automatic int from_lsb(input int cnt_w);
        return cnt_w + ST_W;
    endfunction

    function automatic st_t succ(input st_t f, input int num_states);
        return (int'(f) == num_states - 1) ? '0 : st_t'(f + 1'b1);
    endfunction

    // A jump to state 0 is the FSM's own synchronous reset and is always allowed
    function automatic logic is_legal(input st_t from, input st_t to, input int num_states);
        return (to == '0) || (to == succ(from, num_states));
    endfunction

endpackage

// File: rtl/fsm_mon_fifo.sv
// rtl/fsm_mon_fifo.sv - show-ahead synchronous FIFO holding transition log entries
module fsm_mon_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign head    = valid ? mem[rd_ptr] : '0;
    assign do_pop  = pop && valid;
    // A pop in the same cycle frees the slot the push needs
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fsm_monitor.sv
// rtl/fsm_monitor.sv - ring FSM observer: dwell timing, transition log, error and wrap tracking
module fsm_monitor
    import fsm_mon_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int LOG_DEPTH  = 8,
    parameter int NUM_STATES = 7
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [2:0]                   st_in,
    input  logic                         clear,
    input  logic                         log_ready,
    output logic                         log_valid,
    output logic [CNT_W+5:0]             log_data,
    output logic [$clog2(LOG_DEPTH):0]   log_count,
    output logic                         overflow,
    output logic                         err_illegal,
    output logic [2:0]                   err_state,
    output logic [CNT_W-1:0]             wrap_count,
    output logic [CNT_W-1:0]             dwell_cur
);

    localparam int LW       = CNT_W + 2 * ST_W;
    localparam int TO_LSB   = to_lsb(CNT_W);
    localparam int FROM_LSB = from_lsb(CNT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam st_t LAST_ST = st_t'(NUM_STATES - 1);

    st_t            prev_st;
    logic           primed;
    logic           change;
    logic           bad_sample;
    logic           err_evt;
    logic           wrap_evt;
    logic           push;
    logic           pop;
    logic           full;
    logic [LW-1:0]  entry;

    assign change     = primed && (st_in != prev_st);
    assign bad_sample = (int'(st_in) >= NUM_STATES);
    assign err_evt    = bad_sample || (change && !is_legal(prev_st, st_in, NUM_STATES));
    assign wrap_evt   = change && (prev_st == LAST_ST) && (st_in == '0);
    assign push       = change && !clear;
    assign pop        = log_valid && log_ready;

    always_comb begin
        entry = '0;
        entry[DWELL_LSB +: CNT_W] = dwell_cur;
        entry[TO_LSB    +: ST_W]  = st_in;
        entry[FROM_LSB  +: ST_W]  = prev_st;
    end

    fsm_mon_fifo #(
        .WIDTH (LW),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clock     (clock),
        .reset     (reset),
        .flush     (clear),
        .push      (push),
        .push_data (entry),
        .pop       (pop),
        .head      (log_data),
        .valid     (log_valid),
        .count     (log_count),
        .full      (full)
    );

    // Sampler and dwell counter run regardless of clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_st   <= '0;
            primed    <= 1'b0;
            dwell_cur <= '0;
        end else begin
            prev_st <= st_in;
            primed  <= 1'b1;
            if (!primed || change) begin
                dwell_cur <= CNT_W'(1);
            end else if (dwell_cur != CNT_MAX) begin
                dwell_cur <= dwell_cur + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow    <= 1'b0;
            err_illegal <= 1'b0;
            err_state   <= '0;
            wrap_count  <= '0;
        end else if (clear) begin
            overflow    <= 1'b0;
            err_illegal <= 1'b0;
            err_state   <= '0;
            wrap_count  <= '0;
        end else begin
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
            // err_state keeps the first offending sample only
            if (err_evt) begin
                err_illegal <= 1'b1;
                if (!err_illegal) begin
                    err_state <= st_in;
                end
            end
            if (wrap_evt && (wrap_count != CNT_MAX)) begin
                wrap_count <= wrap_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fsm_monitor.sv
// tb/tb_fsm_monitor.sv - scoreboard bench for fsm_monitor
module tb_fsm_monitor;

    localparam int CNT_W = 16;
    localparam int DEPTH = 8;
    localparam int LW    = CNT_W + 6;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [2:0]       st_in = 3'd0;
    logic             clear = 1'b0;
    logic             log_ready = 1'b0;
    logic             log_valid;
    logic [LW-1:0]    log_data;
    logic [3:0]       log_count;
    logic             overflow;
    logic             err_illegal;
    logic [2:0]       err_state;
    logic [CNT_W-1:0] wrap_count;
    logic [CNT_W-1:0] dwell_cur;

    fsm_monitor #(.CNT_W(CNT_W), .LOG_DEPTH(DEPTH), .NUM_STATES(7)) dut (
        .clock       (clock),
        .reset       (reset),
        .st_in       (st_in),
        .clear       (clear),
        .log_ready   (log_ready),
        .log_valid   (log_valid),
        .log_data    (log_data),
        .log_count   (log_count),
        .overflow    (overflow),
        .err_illegal (err_illegal),
        .err_state   (err_state),
        .wrap_count  (wrap_count),
        .dwell_cur   (dwell_cur)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [LW-1:0]    exp_q[$];
    logic [2:0]       m_prev;
    logic [2:0]       m_est;
    bit               m_primed;
    bit               m_err;
    bit               m_ovf;
    logic [CNT_W-1:0] m_dwell;
    logic [CNT_W-1:0] m_wrap;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_prev = 3'd0; m_est = 3'd0; m_primed = 0; m_err = 0; m_ovf = 0;
        m_dwell = '0; m_wrap = '0;
    endtask

    task automatic check_all();
        chk("log_count", log_count, exp_q.size());
        chk("log_valid", log_valid, exp_q.size() != 0);
        chk("log_data", log_data, (exp_q.size() != 0) ? exp_q[0] : '0);
        chk("dwell_cur", dwell_cur, m_dwell);
        chk("wrap_count", wrap_count, m_wrap);
        chk("overflow", overflow, m_ovf);
        chk("err_illegal", err_illegal, m_err);
        chk("err_state", err_state, m_est);
    endtask

    // Called at a negedge: drive, advance the model by one edge, then check after it
    task automatic step(input logic [2:0] s, input bit rdy = 0, input bit clr = 0);
        bit         change;
        bit         pop;
        bit         e;
        logic [2:0] nx;
        st_in = s; log_ready = rdy; clear = clr;
        pop = rdy && (exp_q.size() > 0);
        if (pop) chk("pop_head", log_data, exp_q[0]);
        change = m_primed && (s != m_prev);
        nx = (m_prev == 3'd6) ? 3'd0 : m_prev + 3'd1;
        e = (s == 3'd7) || (change && !((s == 3'd0) || (s == nx)));
        if (clr) begin
            exp_q.delete();
            m_wrap = '0; m_err = 0; m_est = 3'd0; m_ovf = 0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (change) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({m_prev, s, m_dwell});
                else m_ovf = 1;
            end
            if (e && !m_err) m_est = s;
            if (e) m_err = 1;
            if (change && m_prev == 3'd6 && s == 3'd0 && m_wrap != '1) m_wrap = m_wrap + 1'b1;
        end
        if (!m_primed || change) m_dwell = 1;
        else if (m_dwell != '1) m_dwell = m_dwell + 1'b1;
        m_prev = s; m_primed = 1;
        @(posedge clock);
        @(negedge clock);
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        check_all();
        reset = 1'b1;

        repeat (3) step(3'd0);
        step(3'd1);
        chk("first_entry", log_data, {3'd0, 3'd1, 16'd3});
        chk("first_dwell", dwell_cur, 1);

        step(3'd1);
        for (int s = 2; s <= 6; s++) begin
            step(3'(s));
            step(3'(s));
        end
        step(3'd0);
        step(3'd0);
        chk("walk_count", log_count, 7);
        chk("walk_wrap", wrap_count, 1);
        chk("walk_err", err_illegal, 0);
        repeat (7) step(3'd0, 1);

        step(3'd1); step(3'd2); step(3'd3); step(3'd5);
        chk("err_flag", err_illegal, 1);
        chk("err_first", err_state, 5);
        step(3'd4); step(3'd7);
        chk("err_kept", err_state, 5);
        step(3'd7, 0, 1);
        chk("err_cleared", err_illegal, 0);
        for (int s = 0; s <= 4; s++) step(3'(s));
        step(3'd0);
        chk("reset_jump_ok", err_illegal, 0);

        step(3'd0, 0, 1);
        for (int i = 1; i <= 9; i++) step(3'(i % 7));
        chk("ovf_count", log_count, 8);
        chk("ovf_flag", overflow, 1);
        repeat (8) step(3'd2, 1);
        chk("ovf_drained", log_count, 0);

        step(3'd2, 0, 1);
        for (int i = 3; i <= 10; i++) step(3'(i % 7));
        step(3'd4, 1);
        chk("full_pop_count", log_count, 8);
        chk("full_pop_ovf", overflow, 0);
        repeat (8) step(3'd4, 1);

        step(3'd5); step(3'd6); step(3'd0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("async_valid", log_valid, 0);
        chk("async_wrap", wrap_count, 0);
        check_all();
        @(negedge clock);
        reset = 1'b1;
        step(3'd3);
        chk("post_reset_noentry", log_count, 0);
        step(3'd3);
        step(3'd4);
        chk("post_reset_entry", log_data, {3'd3, 3'd4, 16'd2});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
